// File: rtl/bic_receive_os.sv
// Oversampled bit-in-character sequencer for the UART receive path: counts
// oversample ticks and frame bits, strobes mid-bit, validates start/stop bits.
module bic_receive_os #(
  parameter  int OVERSAMPLE = 16,
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY_EN  = 0,
  parameter  int STOP_BITS  = 1,
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS,
  localparam int BW         = $clog2(FRAME_BITS),
  localparam int OSW        = $clog2(OVERSAMPLE)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          sample_tick,
  input  logic          bic_en,
  input  logic          rx_in,
  input  logic          char_read,
  output logic          sample_strobe,
  output logic [BW-1:0] bit_index,
  output logic          seq_complete,
  output logic          framing_error,
  output logic          start_glitch,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [OSW-1:0] OS_LAST    = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID     = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_HALF    = OSW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0]  LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0]  STOP_FIRST = BW'(FRAME_BITS - STOP_BITS);

  state_t         state, state_n;
  logic [OSW-1:0] os_count, os_count_n;
  logic [BW-1:0]  bit_index_n;
  logic           seq_complete_n;
  logic           framing_error_n;
  logic           start_glitch_n;
  logic           counting;

  // Handshake: seq_complete is a level "valid" held in DONE; char_read is the
  // consumer's acknowledge, sampled on the clock edge, and always wins.
  assign counting      = (state == START) || (state == BITS);
  assign sample_strobe = counting && sample_tick && (os_count == OS_MID);
  assign fsm_state     = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      os_count      <= '0;
      bit_index     <= '0;
      seq_complete  <= 1'b0;
      framing_error <= 1'b0;
      start_glitch  <= 1'b0;
    end else begin
      state         <= state_n;
      os_count      <= os_count_n;
      bit_index     <= bit_index_n;
      seq_complete  <= seq_complete_n;
      framing_error <= framing_error_n;
      start_glitch  <= start_glitch_n;
    end
  end

  always_comb begin
    state_n         = state;
    os_count_n      = os_count;
    bit_index_n     = bit_index;
    seq_complete_n  = seq_complete;
    framing_error_n = framing_error;
    start_glitch_n  = 1'b0;

    if (char_read) begin
      state_n         = IDLE;
      os_count_n      = '0;
      bit_index_n     = '0;
      seq_complete_n  = 1'b0;
      framing_error_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          os_count_n  = '0;
          bit_index_n = '0;
          if (bic_en) state_n = START;
        end

        START, BITS: begin
          if (!bic_en) begin
            state_n     = IDLE;
            os_count_n  = '0;
            bit_index_n = '0;
          end else begin
            if (sample_tick) begin
              if (os_count == OS_LAST) begin
                os_count_n  = '0;
                bit_index_n = bit_index + BW'(1);
                if (state == START) state_n = BITS;
              end else begin
                os_count_n = os_count + OSW'(1);
              end
            end

            if (sample_strobe) begin
              if (state == START) begin
                if (rx_in) begin
                  start_glitch_n = 1'b1;
                  state_n        = ABORT;
                end
              end else begin
                if ((bit_index >= STOP_FIRST) && !rx_in) framing_error_n = 1'b1;
                // Complete at mid-stop-bit so the next start edge can be caught.
                if (bit_index == LAST_BIT) begin
                  state_n        = DONE;
                  seq_complete_n = 1'b1;
                  bit_index_n    = LAST_BIT;
                  os_count_n     = OS_HALF;
                end
              end
            end
          end
        end

        DONE: begin
          seq_complete_n = 1'b1;
          bit_index_n    = LAST_BIT;
          os_count_n     = OS_HALF;
        end

        ABORT: begin
          // Stay parked until the enable drops, so a glitch cannot re-arm.
          if (!bic_en) begin
            state_n     = IDLE;
            os_count_n  = '0;
            bit_index_n = '0;
          end
        end

        default: begin
          state_n     = IDLE;
          os_count_n  = '0;
          bit_index_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bic_receive_os.sv
// Directed bench for bic_receive_os: table of full frames on the default
// configuration plus hand-written glitch/abort/reset sequences and an 8x config.
module tb_bic_receive_os;

  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_BITS  = 2;
  localparam int S_DONE  = 3;
  localparam int S_ABORT = 4;

  logic       clock;
  logic       reset_n;

  // default configuration DUT
  logic       sample_tick, bic_en, rx_in, char_read;
  logic       sample_strobe, seq_complete, framing_error, start_glitch;
  logic [3:0] bit_index;
  logic [2:0] fsm_state;

  // OVERSAMPLE=8, 7 data, parity, 2 stop DUT
  logic       b_tick, b_en, b_rx, b_read;
  logic       b_strobe, b_complete, b_ferr, b_glitch;
  logic [3:0] b_index;
  logic [2:0] b_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_low;
    bit         read_at_last;
    bit         exp_complete;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  bic_receive_os dut (
    .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .bic_en(bic_en),
    .rx_in(rx_in), .char_read(char_read), .sample_strobe(sample_strobe),
    .bit_index(bit_index), .seq_complete(seq_complete), .framing_error(framing_error),
    .start_glitch(start_glitch), .fsm_state(fsm_state)
  );

  bic_receive_os #(.OVERSAMPLE(8), .DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .sample_tick(b_tick), .bic_en(b_en),
    .rx_in(b_rx), .char_read(b_read), .sample_strobe(b_strobe),
    .bit_index(b_index), .seq_complete(b_complete), .framing_error(b_ferr),
    .start_glitch(b_glitch), .fsm_state(b_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired, actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic frame_bit(input vec_t v, input int b);
    if (b < 0 || b > 9) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return !v.stop_low;
    return v.data[b-1];
  endfunction

  // Starts at posedge+1 in IDLE; bic_en is sampled high at the end of cycle 0.
  task automatic run_vector(input vec_t v, input int id);
    for (int c = 0; c <= 165; c++) begin
      int  exp_idx, exp_st;
      bit  exp_strobe, exp_done;
      sample_tick = 1'b1;
      bic_en      = (c <= 152);
      char_read   = (c == 160) || (v.read_at_last && c == 152);
      rx_in       = frame_bit(v, (c >= 1) ? (c - 1) / 16 : -1);
      @(negedge clock);
      exp_strobe = (c >= 8) && (c <= 152) && ((c - 8) % 16 == 0);
      exp_done   = v.exp_complete && (c >= 153) && (c <= 160);
      if (c == 0)        exp_idx = 0;
      else if (c <= 152) exp_idx = (c - 1) / 16;
      else if (exp_done) exp_idx = 9;
      else               exp_idx = 0;
      if (c == 0)        exp_st = S_IDLE;
      else if (c <= 16)  exp_st = S_START;
      else if (c <= 152) exp_st = S_BITS;
      else if (exp_done) exp_st = S_DONE;
      else               exp_st = S_IDLE;
      chk($sformatf("v%0d_strobe_c%0d", id, c), int'(sample_strobe), int'(exp_strobe));
      chk($sformatf("v%0d_index_c%0d", id, c), int'(bit_index), exp_idx);
      chk($sformatf("v%0d_state_c%0d", id, c), int'(fsm_state), exp_st);
      chk($sformatf("v%0d_complete_c%0d", id, c), int'(seq_complete), int'(exp_done));
      chk($sformatf("v%0d_ferr_c%0d", id, c), int'(framing_error), int'(exp_done && v.exp_ferr));
      chk($sformatf("v%0d_glitch_c%0d", id, c), int'(start_glitch), 0);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop_low: 1'b0, read_at_last: 1'b0, exp_complete: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA5, stop_low: 1'b1, read_at_last: 1'b0, exp_complete: 1'b1, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h3C, stop_low: 1'b0, read_at_last: 1'b1, exp_complete: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop_low: 1'b0, read_at_last: 1'b0, exp_complete: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h00, stop_low: 1'b1, read_at_last: 1'b0, exp_complete: 1'b1, exp_ferr: 1'b1};

    reset_n = 1'b0;
    sample_tick = 1'b0; bic_en = 1'b0; rx_in = 1'b1; char_read = 1'b0;
    b_tick = 1'b0; b_en = 1'b0; b_rx = 1'b1; b_read = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", int'(fsm_state), S_IDLE);
    chk("reset_index", int'(bit_index), 0);
    chk("reset_complete", int'(seq_complete), 0);
    chk("reset_ferr", int'(framing_error), 0);
    chk("reset_glitch", int'(start_glitch), 0);
    chk("reset_strobe", int'(sample_strobe), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // table of full frames
    for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

    // start bit high at mid-sample: glitch pulse, park in ABORT, then release
    for (int c = 0; c <= 45; c++) begin
      sample_tick = 1'b1;
      bic_en      = (c < 40);
      rx_in       = 1'b1;
      char_read   = 1'b0;
      @(negedge clock);
      chk($sformatf("glitch_strobe_c%0d", c), int'(sample_strobe), int'(c == 8));
      chk($sformatf("glitch_pulse_c%0d", c), int'(start_glitch), int'(c == 9));
      if (c == 20) chk("glitch_abort_state", int'(fsm_state), S_ABORT);
      if (c == 39) chk("glitch_abort_hold", int'(fsm_state), S_ABORT);
      if (c == 41) chk("glitch_idle_after_en", int'(fsm_state), S_IDLE);
      chk($sformatf("glitch_complete_c%0d", c), int'(seq_complete), 0);
      @(posedge clock);
      #1;
    end
    run_vector(vecs[0], 10);

    // bic_en dropped while bit_index = 5
    for (int c = 0; c <= 90; c++) begin
      sample_tick = 1'b1;
      bic_en      = (c < 85);
      rx_in       = 1'b0;
      char_read   = 1'b0;
      @(negedge clock);
      if (c == 84) chk("abort_index_before", int'(bit_index), 5);
      if (c == 86) begin
        chk("abort_state", int'(fsm_state), S_IDLE);
        chk("abort_index", int'(bit_index), 0);
        chk("abort_complete", int'(seq_complete), 0);
        chk("abort_ferr", int'(framing_error), 0);
        chk("abort_glitch", int'(start_glitch), 0);
      end
      if (c >= 86) chk($sformatf("abort_no_strobe_c%0d", c), int'(sample_strobe), 0);
      @(posedge clock);
      #1;
    end
    run_vector(vecs[1], 11);

    // asynchronous reset while bit_index = 3
    for (int c = 0; c <= 55; c++) begin
      sample_tick = 1'b1;
      bic_en      = 1'b1;
      rx_in       = 1'b0;
      char_read   = 1'b0;
      @(negedge clock);
      if (c == 55) begin
        chk("rst_index_before", int'(bit_index), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_state", int'(fsm_state), S_IDLE);
        chk("rst_async_index", int'(bit_index), 0);
        chk("rst_async_strobe", int'(sample_strobe), 0);
        chk("rst_async_complete", int'(seq_complete), 0);
        chk("rst_async_ferr", int'(framing_error), 0);
        chk("rst_async_glitch", int'(start_glitch), 0);
      end else begin
        @(posedge clock);
        #1;
      end
    end
    bic_en = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_resume_state", int'(fsm_state), S_IDLE);
    chk("rst_resume_index", int'(bit_index), 0);
    run_vector(vecs[3], 12);

    // 8x oversampling, 11-bit frame, tick every 4th cycle
    for (int k = 0; k < 11; k++) exp_q.push_back(16'(13 + 32 * k));
    for (int c = 0; c <= 360; c++) begin
      b_tick = (c % 4 == 1);
      b_en   = (c <= 333);
      b_rx   = (c < 30) ? 1'b0 : 1'b1;
      b_read = (c == 350);
      @(negedge clock);
      if (b_strobe) got_q.push_back(16'(c));
      if (c == 333) chk("b_complete_before", int'(b_complete), 0);
      if (c == 334) chk("b_complete_rise", int'(b_complete), 1);
      if (c == 334) chk("b_index_done", int'(b_index), 10);
      if (c == 340) chk("b_ferr", int'(b_ferr), 0);
      if (c == 351) chk("b_complete_fall", int'(b_complete), 0);
      if (c == 351) chk("b_state_idle", int'(b_state), S_IDLE);
      @(posedge clock);
      #1;
    end
    chk("b_strobe_count", got_q.size(), 11);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [15:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("b_strobe_cycle", int'(g), int'(e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
